// File: rtl/rv32i_types.sv
// Shared RV32I types for the memory stage: data word, load/store encodings, controller states.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [2:0] {
        Lb  = 3'b000,
        Lh  = 3'b001,
        Lw  = 3'b010,
        Lbu = 3'b100,
        Lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        Sb = 3'b000,
        Sh = 3'b001,
        Sw = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone
    } mem_ctrl_state_t;

endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane helper: legality check, store mask/shift, load extract/extend.
module mem_align
    import rv32i_types::*;
(
    input  logic       is_load_i,
    input  logic       is_store_i,
    input  logic [2:0] funct3_i,
    input  logic [1:0] offset_i,
    input  rv32i_word  wdata_i,
    input  rv32i_word  rdata_i,
    output logic       legal_o,
    output logic [3:0] byte_en_o,
    output rv32i_word  wdata_o,
    output rv32i_word  rdata_o
);

    rv32i_word rdata_shifted;

    assign wdata_o       = wdata_i << {offset_i, 3'b000};
    assign rdata_shifted = rdata_i >> {offset_i, 3'b000};

    // Legality: known funct3 for the access kind, and natural alignment for halves/words.
    always_comb begin
        legal_o = 1'b0;
        if (is_load_i) begin
            case (load_funct3_t'(funct3_i))
                Lb, Lbu:  legal_o = 1'b1;
                Lh, Lhu:  legal_o = ~offset_i[0];
                Lw:       legal_o = (offset_i == 2'b00);
                default:  legal_o = 1'b0;
            endcase
        end else if (is_store_i) begin
            case (store_funct3_t'(funct3_i))
                Sb:       legal_o = 1'b1;
                Sh:       legal_o = ~offset_i[0];
                Sw:       legal_o = (offset_i == 2'b00);
                default:  legal_o = 1'b0;
            endcase
        end
    end

    // Store byte mask; loads never enable write lanes.
    always_comb begin
        byte_en_o = 4'b0000;
        if (is_store_i) begin
            case (store_funct3_t'(funct3_i))
                Sb:       byte_en_o = 4'b0001 << offset_i;
                Sh:       byte_en_o = 4'b0011 << offset_i;
                Sw:       byte_en_o = 4'b1111;
                default:  byte_en_o = 4'b0000;
            endcase
        end
    end

    // Load extraction with sign or zero extension.
    always_comb begin
        rdata_o = rdata_i;
        case (load_funct3_t'(funct3_i))
            Lb:       rdata_o = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            Lbu:      rdata_o = {24'h000000, rdata_shifted[7:0]};
            Lh:       rdata_o = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            Lhu:      rdata_o = {16'h0000, rdata_shifted[15:0]};
            default:  rdata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data access controller: one cache transaction per load/store, stalling until resp.
module mem_access_ctrl
    import rv32i_types::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic       req_load,
    input  logic       req_store,
    input  logic [2:0] req_funct3,
    input  rv32i_word  req_addr,
    input  rv32i_word  req_wdata,
    output logic       mem_read,
    output logic       mem_write,
    output rv32i_word  mem_address,
    output rv32i_word  mem_wdata,
    output logic [3:0] mem_byte_enable,
    input  logic       mem_resp,
    input  rv32i_word  mem_rdata,
    output logic       stall,
    output rv32i_word  rdata,
    output logic       access_fault
);

    mem_ctrl_state_t state_q, state_d;
    logic            load_q, store_q;
    logic [2:0]      funct3_q;
    rv32i_word       addr_q, wdata_q, rdata_q;
    logic [3:0]      be_q;

    logic            req_any, req_legal, accept;
    logic [3:0]      req_be;
    rv32i_word       req_wdata_lane, rsp_rdata;
    logic            rsp_legal_unused;
    logic [3:0]      rsp_be_unused;
    rv32i_word       req_rdata_unused, rsp_wdata_unused;

    mem_align u_req_align (
        .is_load_i  (req_load),
        .is_store_i (req_store),
        .funct3_i   (req_funct3),
        .offset_i   (req_addr[1:0]),
        .wdata_i    (req_wdata),
        .rdata_i    (32'h0000_0000),
        .legal_o    (req_legal),
        .byte_en_o  (req_be),
        .wdata_o    (req_wdata_lane),
        .rdata_o    (req_rdata_unused)
    );

    mem_align u_rsp_align (
        .is_load_i  (load_q),
        .is_store_i (store_q),
        .funct3_i   (funct3_q),
        .offset_i   (addr_q[1:0]),
        .wdata_i    (wdata_q),
        .rdata_i    (mem_rdata),
        .legal_o    (rsp_legal_unused),
        .byte_en_o  (rsp_be_unused),
        .wdata_o    (rsp_wdata_unused),
        .rdata_o    (rsp_rdata)
    );

    assign req_any = req_valid & (req_load | req_store);
    assign accept  = (state_q == StIdle) & req_any & req_legal;

    // Next-state logic; DONE always falls back to IDLE so the serviced instruction is ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (accept) state_d = StAccess;
            StAccess: if (mem_resp) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Outputs; combinational terms are gated by rst_n so everything reads 0 during reset.
    always_comb begin
        mem_read        = (state_q == StAccess) & load_q;
        mem_write       = (state_q == StAccess) & store_q;
        mem_address     = {addr_q[31:2], 2'b00};
        mem_wdata       = wdata_q;
        mem_byte_enable = be_q;
        rdata           = rdata_q;
        stall           = rst_n & (accept | (state_q == StAccess));
        access_fault    = rst_n & (state_q == StIdle) & req_any & ~req_legal;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Request capture on accept; held stable through ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_q   <= 1'b0;
            store_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= 4'b0000;
        end else if (accept) begin
            load_q   <= req_load;
            store_q  <= req_store;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata_lane;
            be_q     <= req_be;
        end
    end

    // Load result capture; stores and stray responses leave it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if ((state_q == StAccess) && mem_resp && load_q) begin
            rdata_q <= rsp_rdata;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: vector table, scoreboard of load results, corner cases.
module tb_mem_access_ctrl;
    import rv32i_types::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_load, req_store;
    logic [2:0] req_funct3;
    rv32i_word  req_addr, req_wdata;
    logic       mem_read, mem_write;
    rv32i_word  mem_address, mem_wdata;
    logic [3:0] mem_byte_enable;
    logic       mem_resp;
    rv32i_word  mem_rdata;
    logic       stall;
    rv32i_word  rdata;
    logic       access_fault;

    int total = 0;
    int bad   = 0;
    int reads = 0;
    int writes = 0;
    rv32i_word exp_q[$];
    rv32i_word last_rdata = 32'h0;
    logic [15:0] stall_log = '0;

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] mrd;
        logic        fault;
        logic [3:0]  be;
        logic [31:0] ewd;
        logic [31:0] erd;
    } vec_t;

    vec_t vecs[16];

    mem_access_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_load        (req_load),
        .req_store       (req_store),
        .req_funct3      (req_funct3),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_resp        (mem_resp),
        .mem_rdata       (mem_rdata),
        .stall           (stall),
        .rdata           (rdata),
        .access_fault    (access_fault)
    );

    always #5 clk = ~clk;

    // Strobe counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_read)  reads++;
            if (mem_write) writes++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic log_stall();
        stall_log = {stall_log[14:0], stall};
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0; mem_resp = 1'b0;
        @(negedge clk);
        log_stall();
        check("idle stall", {31'b0, stall}, 32'd0);
        check("idle strobes", {30'b0, mem_read, mem_write}, 32'd0);
        check("idle fault", {31'b0, access_fault}, 32'd0);
    endtask

    // Legal access with response `lat` cycles after the strobe rises; leaves req held in DONE.
    task automatic do_access(input string name, input logic ld, input logic st, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] mrd,
                             input int lat, input logic [3:0] be, input logic [31:0] ewd,
                             input logic [31:0] erd);
        int r0, w0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_load = ld; req_store = st; req_funct3 = f3;
        req_addr = addr; req_wdata = wd; mem_resp = 1'b0;
        exp_q.push_back(ld ? erd : last_rdata);
        if (ld) last_rdata = erd;
        r0 = reads; w0 = writes;
        @(negedge clk);
        log_stall();
        check({name, " accept stall"}, {31'b0, stall}, 32'd1);
        check({name, " accept fault"}, {31'b0, access_fault}, 32'd0);
        check({name, " accept strobes"}, {30'b0, mem_read, mem_write}, 32'd0);
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk); #1;
            mem_resp  = (k == lat);
            mem_rdata = (k == lat) ? mrd : 32'h5A5A_5A5A;
            @(negedge clk);
            log_stall();
            check({name, " access stall"}, {31'b0, stall}, 32'd1);
            check({name, " strobes"}, {30'b0, mem_read, mem_write}, {30'b0, ld, st});
            check({name, " address"}, mem_address, {addr[31:2], 2'b00});
            check({name, " byte_enable"}, {28'b0, mem_byte_enable}, {28'b0, be});
            if (st) check({name, " wdata"}, mem_wdata, ewd);
        end
        @(posedge clk); #1;
        mem_resp = 1'b0;
        @(negedge clk);
        log_stall();
        check({name, " done stall"}, {31'b0, stall}, 32'd0);
        check({name, " done strobes"}, {30'b0, mem_read, mem_write}, 32'd0);
        check({name, " rdata"}, rdata, exp_q.pop_front());
        check({name, " reads issued"}, reads - r0, ld ? lat : 0);
        check({name, " writes issued"}, writes - w0, st ? lat : 0);
    endtask

    task automatic fault_case(input string name, input logic ld, input logic st,
                              input logic [2:0] f3, input logic [31:0] addr);
        int r0, w0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_load = ld; req_store = st; req_funct3 = f3;
        req_addr = addr; req_wdata = 32'h1357_9BDF; mem_resp = 1'b0;
        r0 = reads; w0 = writes;
        @(negedge clk);
        check({name, " fault"}, {31'b0, access_fault}, 32'd1);
        check({name, " stall"}, {31'b0, stall}, 32'd0);
        check({name, " strobes"}, {30'b0, mem_read, mem_write}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check({name, " held fault"}, {31'b0, access_fault}, 32'd1);
        check({name, " held strobes"}, {30'b0, mem_read, mem_write}, 32'd0);
        idle_cycle();
        check({name, " no access"}, (reads - r0) + (writes - w0), 32'd0);
    endtask

    initial begin
        //            ld    st    f3      addr          wd            mrd           flt   be       ewd           erd
        vecs[0]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_1234, 1'b0, 4'b0000, 32'h0,        32'hFFFF_FF80};
        vecs[1]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF_1234, 1'b0, 4'b0000, 32'h0,        32'h0000_0080};
        vecs[2]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h80FF_1234, 1'b0, 4'b0000, 32'h0,        32'hFFFF_80FF};
        vecs[3]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0,        32'h80FF_1234, 1'b0, 4'b0000, 32'h0,        32'h0000_80FF};
        vecs[4]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0100, 32'h0,        32'h80FF_1234, 1'b0, 4'b0000, 32'h0,        32'h0000_0034};
        vecs[5]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0,        32'h1234_5678, 1'b0, 4'b0000, 32'h0,        32'h1234_5678};
        vecs[6]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h0000_00AB, 32'hFFFF_FFFF, 1'b0, 4'b0010, 32'h0000_AB00, 32'h0};
        vecs[7]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 32'hFFFF_FFFF, 1'b0, 4'b1100, 32'hABCD_0000, 32'h0};
        vecs[8]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 32'hFFFF_FFFF, 1'b0, 4'b1111, 32'hCAFE_F00D, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0100, 32'h0,        32'h0000_FFFE, 1'b0, 4'b0000, 32'h0,        32'hFFFF_FFFE};
        vecs[10] = '{1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0,        32'h0,         1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[11] = '{1'b0, 1'b1, 3'b001, 32'h0000_0103, 32'h0,        32'h0,         1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[12] = '{1'b1, 1'b0, 3'b011, 32'h0000_0000, 32'h0,        32'h0,         1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[13] = '{1'b0, 1'b1, 3'b100, 32'h0000_0000, 32'h0,        32'h0,         1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[14] = '{1'b1, 1'b0, 3'b101, 32'h0000_0101, 32'h0,        32'h0,         1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[15] = '{1'b1, 1'b0, 3'b001, 32'h0000_0103, 32'h0,        32'h0,         1'b1, 4'b0000, 32'h0,        32'h0};

        // Reset state, with a request presented to show combinational outputs stay low.
        rst_n = 1'b0;
        req_valid = 1'b1; req_load = 1'b1; req_store = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h0000_0040; req_wdata = 32'h0; mem_resp = 1'b0; mem_rdata = 32'h0;
        #2;
        check("reset strobes", {30'b0, mem_read, mem_write}, 32'd0);
        check("reset address", mem_address, 32'h0);
        check("reset wdata", mem_wdata, 32'h0);
        check("reset byte_enable", {28'b0, mem_byte_enable}, 32'h0);
        check("reset stall", {31'b0, stall}, 32'd0);
        check("reset rdata", rdata, 32'h0);
        check("reset fault", {31'b0, access_fault}, 32'd0);
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle_cycle();

        // LW with a 3-cycle response: 4 stall cycles, 3 read cycles, one transaction.
        stall_log = '0;
        do_access("lw_1004", 1'b1, 1'b0, 3'b010, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 3,
                  4'b0000, 32'h0, 32'hDEAD_BEEF);
        check("lw_1004 stall pattern", {27'b0, stall_log[4:0]}, 32'b11110);
        idle_cycle();

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].fault) begin
                fault_case($sformatf("vec%0d", i), vecs[i].ld, vecs[i].st, vecs[i].f3, vecs[i].addr);
            end else begin
                do_access($sformatf("vec%0d", i), vecs[i].ld, vecs[i].st, vecs[i].f3, vecs[i].addr,
                          vecs[i].wd, vecs[i].mrd, 1 + (i % 3), vecs[i].be, vecs[i].ewd,
                          vecs[i].erd);
                idle_cycle();
            end
        end

        // Back-to-back LWs answered on the first ACCESS cycle.
        stall_log = '0;
        do_access("b2b_a", 1'b1, 1'b0, 3'b010, 32'h0000_2000, 32'h0, 32'h1111_1111, 1,
                  4'b0000, 32'h0, 32'h1111_1111);
        do_access("b2b_b", 1'b1, 1'b0, 3'b010, 32'h0000_2004, 32'h0, 32'h2222_2222, 1,
                  4'b0000, 32'h0, 32'h2222_2222);
        check("b2b stall pattern", {26'b0, stall_log[5:0]}, 32'b110110);
        idle_cycle();

        // Reset pulled two cycles into ACCESS of an SW; late response afterwards is ignored.
        @(posedge clk); #1;
        req_valid = 1'b1; req_load = 1'b0; req_store = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h0000_0400; req_wdata = 32'h1234_5678;
        @(negedge clk);
        check("rst_sw accept stall", {31'b0, stall}, 32'd1);
        repeat (2) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("rst_sw access write", {31'b0, mem_write}, 32'd1);
        end
        #2 rst_n = 1'b0;
        #1;
        check("rst_sw write drop", {31'b0, mem_write}, 32'd0);
        check("rst_sw stall drop", {31'b0, stall}, 32'd0);
        check("rst_sw address clear", mem_address, 32'h0);
        req_valid = 1'b0; req_store = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        mem_resp = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check("late resp strobes", {30'b0, mem_read, mem_write}, 32'd0);
        check("late resp stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        mem_resp = 1'b0;
        @(negedge clk);
        check("late resp rdata", rdata, 32'h0);
        check("late resp idle", {29'b0, mem_read, mem_write, stall}, 32'd0);
        last_rdata = 32'h0;
        do_access("post_rst_lw", 1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0, 32'h0BAD_F00D, 2,
                  4'b0000, 32'h0, 32'h0BAD_F00D);
        idle_cycle();

        check("scoreboard drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
